// File: rtl/adder_b_cla_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// The master side presents operands with in_valid. The slave side returns
// the registered sum, the carry-out and a one-cycle out_valid pulse.
interface adder_b_cla_if #(
  parameter int N_BIT = 13
);
  logic           in_valid;
  logic [N_BIT:0] a;
  logic [N_BIT:0] b;
  logic           car;
  logic [N_BIT:0] out;
  logic           car_out;
  logic           out_valid;

  modport master (
    output in_valid, a, b, car,
    input  out, car_out, out_valid
  );

  modport slave (
    input  in_valid, a, b, car,
    output out, car_out, out_valid
  );
endinterface

// File: rtl/adder_b_cla.sv
// Registered carry-lookahead adder. Computes {car_out, out} = a + b + car
// over N_BIT+1 bit unsigned operands and registers the result.
// Every carry is a flat sum of generate/propagate products, so the
// operand-to-register path never depends on a ripple chain.
module adder_b_cla #(
  parameter int N_BIT = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_b_cla_if.slave  bus
);
  localparam int W = N_BIT + 1;

  // Mask with bits [lo, hi) set. When lo == hi the mask is empty, and the
  // product of propagates over that span reduces to 1.
  function automatic logic [W-1:0] span_mask(input int lo, input int hi);
    logic [W-1:0] m;
    m = '0;
    for (int k = 0; k < W; k++) begin
      m[k] = (k >= lo) && (k < hi);
    end
    return m;
  endfunction

  logic [W-1:0] g_s;   // generate terms
  logic [W-1:0] p_s;   // propagate terms (inclusive OR)
  logic [W-1:0] h_s;   // half-sum, equal to a ^ b
  logic [W:0]   c_s;   // carry into each bit, c_s[W] is the carry-out
  logic [W-1:0] s_s;   // combinational sum

  logic [W-1:0] out_r;
  logic         car_out_r;
  logic         out_valid_r;

  assign g_s = bus.a & bus.b;
  assign p_s = bus.a | bus.b;
  assign h_s = ~g_s & p_s;

  assign c_s[0] = bus.car;

  // Carry i is the OR of these terms:
  //   - the carry-in term: car propagated through bits 0..i-1;
  //   - one term per bit j < i: g[j] propagated through bits j+1..i-1.
  // Each term is a single wide AND. The OR spans all terms in one level.
  // No carry is derived from the previous one.
  for (genvar i = 1; i <= W; i++) begin : g_carry
    logic [i:0] term_s;

    assign term_s[0] = bus.car & (&(p_s | ~span_mask(0, i)));

    for (genvar j = 0; j < i; j++) begin : g_term
      assign term_s[j+1] = g_s[j] & (&(p_s | ~span_mask(j + 1, i)));
    end

    assign c_s[i] = |term_s;
  end

  assign s_s = h_s ^ c_s[W-1:0];

  // Result register: capture on in_valid, otherwise hold the result and
  // clear out_valid. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {W{1'b0}};
      car_out_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        out_r     <= s_s;
        car_out_r <= c_s[W];
      end else begin
        out_r     <= out_r;
        car_out_r <= car_out_r;
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.car_out   = car_out_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_adder_b_cla.sv
// Self-checking bench for adder_b_cla.
// The reference is plain integer addition a + b + car. Results are compared
// one cycle after each capture as {out_valid, car_out, out}.
module tb_adder_b_cla;
  localparam int NB  = 13;
  localparam int W   = NB + 1;
  localparam int NB3 = 3;
  localparam int W3  = NB3 + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  adder_b_cla_if #(.N_BIT(NB))  bus  ();
  adder_b_cla_if #(.N_BIT(NB3)) bus3 ();

  adder_b_cla #(.N_BIT(NB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  adder_b_cla #(.N_BIT(NB3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_sum(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    return 32'(a + b + c);
  endfunction

  function automatic logic [31:0] main_obs();
    return 32'({bus.out_valid, bus.car_out, bus.out});
  endfunction

  // Capture one operand set on the wide adder and check the result after the edge.
  task automatic add_and_check(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic c);
    logic [31:0] exp;
    @(negedge clk);
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.car      = c;
    bus.in_valid = 1'b1;
    exp = (32'd1 << (W + 1)) | ref_sum(32'(a[W-1:0]), 32'(b[W-1:0]), 32'(c));
    @(posedge clk);
    #1;
    check_eq(tag, main_obs(), exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] exp3;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.car       = 1'b0;
    bus3.in_valid = 1'b0;
    bus3.a        = '0;
    bus3.b        = '0;
    bus3.car      = 1'b0;

    // Power-on reset.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", main_obs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a cycle while out = 0x1ABC.
    add_and_check("pre_reset", 32'h1000, 32'h0ABC, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset", main_obs(), 32'd0);
    // While reset is held, captures are blocked even with in_valid high.
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("reset_blocks", main_obs(), 32'd0);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("post_release_idle", main_obs(), 32'd0);
    end

    // Directed cases.
    add_and_check("basic_add",  32'h1234, 32'h0F0F, 1'b0);
    add_and_check("chain_zero", 32'h3FFF, 32'h0000, 1'b1);
    add_and_check("chain_full", 32'h3FFF, 32'h3FFF, 1'b1);

    // Hold behaviour: out stays 3 while in_valid is low, and out_valid pulses once.
    add_and_check("hold_capture", 32'h0001, 32'h0001, 1'b1);
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.car      = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("hold", main_obs(), 32'h0003);
    end

    // Back-to-back random stream.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom_range(0, (1 << W) - 1);
      rb = $urandom_range(0, (1 << W) - 1);
      add_and_check("stream_rand", ra, rb, 1'($urandom));
    end

    // Every a = ~b case, each on its own back-to-back cycle.
    for (int i = 0; i < (1 << W); i++) begin
      ra = 32'(i);
      rb = ~ra & ((32'd1 << W) - 32'd1);
      add_and_check("stream_a_not_b", ra, rb, 1'($urandom));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("valid_drop", 32'(bus.out_valid), 32'd0);

    // Exhaustive sweep of the narrow instance.
    for (int i = 0; i < 512; i++) begin
      ra = 32'(i) & 32'hF;
      rb = (32'(i) >> 4) & 32'hF;
      @(negedge clk);
      bus3.a        = ra[W3-1:0];
      bus3.b        = rb[W3-1:0];
      bus3.car      = 1'((i >> 8) & 1);
      bus3.in_valid = 1'b1;
      exp3 = (32'd1 << (W3 + 1)) | ref_sum(ra, rb, 32'((i >> 8) & 1));
      @(posedge clk);
      #1;
      check_eq("sweep_n3", 32'({bus3.out_valid, bus3.car_out, bus3.out}), exp3);
    end
    @(negedge clk);
    bus3.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adder_b_cla.md
# adder_b_cla

Registered carry-lookahead adder of parameterizable width. It adds two (N_BIT+1)-bit operands and a carry-in, and produces an (N_BIT+1)-bit sum plus carry-out. It serves as the final carry-propagate stage of the bfloat16 mantissa multiplier: it sums the two rows left by the Wallace/Dadda reduction tree, using N_BIT=13 and carry-in tied to 0. Every sum bit is computed with flat generate/propagate lookahead, and the result is captured in an output register.

## Interface
- N_BIT, 13: MSB index of the operands. Operand and sum width is N_BIT+1 (14 bits by default). Legal range is 2..31.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  when high, the operands on this cycle are captured.
- a  input  N_BIT+1  operand A, unsigned.
- b  input  N_BIT+1  operand B, unsigned.
- car  input  1  carry-in.
- out  output  N_BIT+1  registered sum bits [N_BIT:0].
- car_out  output  1  registered carry-out (bit N_BIT+1 of the full sum).
- out_valid  output  1  registered; high for exactly one cycle after a capture.

## Operation
- Bitwise terms:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] | b[i]
  - half-sum h[i] = ~g[i] & p[i], which equals a[i]^b[i].
- Carry vector c[0..N_BIT+1]:
  - c[0] = car.
  - c[1] = g[0] | (car & p[0]).
  - c[i] = g[i-1] | OR over j<i-1 of (g[j] & p[j+1] & … & p[i-1]) | (car & p[0] & … & p[i-1]).
  - Each c[i] is a flat sum of products built in a generate loop. Do not chain c[i] from c[i-1] (no ripple).
- Sum: s[i] = h[i] ^ c[i] for i = 0..N_BIT. Carry-out co = c[N_BIT+1].
- Arithmetic identity, which must hold for all inputs: {co, s} = a + b + car, exact and unsigned, N_BIT+2 bits wide. No saturation; wrap-around is reported only through co.
- Register stage:
  - On a rising clk with in_valid=1: out <= s, car_out <= co, out_valid <= 1.
  - On a rising clk with in_valid=0: out and car_out hold their previous values, out_valid <= 0.
- X/Z on a, b or car while in_valid=0 has no effect on the outputs.

## Timing
- Latency is 1 cycle: operands presented at edge k appear on out/car_out/out_valid after edge k.
- Throughput is one addition per cycle. Back-to-back in_valid is fully supported, with no bubbles or stalls.
- There is no backpressure. A downstream consumer must sample on out_valid.
- Reset:
  - When rst_n falls, out, car_out and out_valid go to 0 immediately, without waiting for clk.
  - While rst_n=0, captures are blocked.
  - The first capture after release occurs on the first rising clk with rst_n=1 and in_valid=1.
  - An operation in flight when reset asserts is discarded. out_valid does not pulse for it.
- Combinational path a/b/car → register D is bounded by the lookahead depth (one AND level plus one OR level per carry, log-depth tree). No path may depend on the ripple length.

## Test plan
- Reset: drive rst_n=0 mid-cycle while out=0x1ABC → out=0x0000, car_out=0 and out_valid=0 immediately. After release with in_valid=0, these stay 0.
- Basic add: a=0x1234, b=0x0F0F, car=0, in_valid=1 → next cycle out=0x2143, car_out=0, out_valid=1.
- Full carry chain: a=0x3FFF, b=0x0000, car=1 → out=0x0000, car_out=1. Also a=0x3FFF, b=0x3FFF, car=1 → out=0x3FFF, car_out=1.
- Hold and valid pulse:
  - Capture a=0x0001, b=0x0001, car=1 → out=0x0003.
  - Then drop in_valid and toggle a/b randomly for 3 cycles → out stays 0x0003 and out_valid is high for exactly 1 cycle.
- Throughput: stream 1000 random {a,b,car} with in_valid=1 every cycle. Each cycle must match {car_out,out} = a+b+car from the previous cycle, including all 2^(N_BIT+1) boundary cases with a=~b.
- Parameter sweep: N_BIT=3 exhaustive (all 512 combinations of a, b, car) → every result equals a+b+car.
